// File: rtl/paddle_timer_pkg.sv
// ---------------------------------------------------------------------------
// paddle_timer_pkg
// Shared constants and helpers for the game-port paddle timer.
//   PDL_CENTER / PDL_SCALE map a signed 8-bit paddle position onto a tick
//   count; PDL_CLAMP / PDL_MAX bound the top of the range; PDL_CNT_W is the
//   width of each channel's down-counter.
//   ch_state_e is the two-state life cycle of one paddle channel.
//   pdl_load_value() turns one paddle position into a clamped counter load.
// ---------------------------------------------------------------------------
package paddle_timer_pkg;

  localparam int PDL_CENTER = 2800;
  localparam int PDL_SCALE  = 22;
  localparam int PDL_CLAMP  = 5590;
  localparam int PDL_MAX    = 5650;
  localparam int PDL_CNT_W  = 13;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Centre + scale * position, done in 16-bit signed arithmetic. The raw
  // result spans -16..5594, so 16 bits never overflow. Anything that lands
  // at or above the clamp point is pushed out to the full-scale count.
  function automatic logic [PDL_CNT_W-1:0] pdl_load_value(input logic [7:0] pos);
    logic signed [15:0] pos_s;
    logic signed [15:0] raw;
    logic [PDL_CNT_W-1:0] result;
    pos_s = {{8{pos[7]}}, pos};
    raw   = 16'(PDL_CENTER) + 16'(PDL_SCALE) * pos_s;
    if (raw < 16'sd0) begin
      result = '0;
    end else if (raw >= 16'(PDL_CLAMP)) begin
      result = PDL_CNT_W'(PDL_MAX);
    end else begin
      result = raw[PDL_CNT_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/paddle_timer_channel.sv
// ---------------------------------------------------------------------------
// paddle_channel
// One paddle channel: a 13-bit down-counter that is loaded from the paddle
// position on a serviced strobe and counts down once per CPU tick, plus the
// registered output that is high exactly while the counter is non-zero.
//   clk    in   master clock
//   reset  in   synchronous active-high reset
//   tick   in   one-cycle pulse per CPU-phase clock rising edge
//   load   in   reload request; only ever asserted together with tick
//   pos    in   signed 8-bit paddle position
//   pdl    out  channel output, high while the count is running
// ---------------------------------------------------------------------------
module paddle_channel
  import paddle_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] pos,
  output logic       pdl
);

  logic [PDL_CNT_W-1:0] cnt_q;
  logic [PDL_CNT_W-1:0] cnt_d;
  ch_state_e            state_q;
  ch_state_e            state_d;

  // Counter next value. A load always wins, so a strobe during a running
  // count simply restarts it from the current position. A count of zero is
  // left alone on a tick so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = pdl_load_value(pos);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Channel state follows the counter: it enters RUN when a non-zero value
  // is loaded and drops back to IDLE on the tick that takes the count to
  // zero. Deciding from cnt_d makes the registered output change on the same
  // edge as the counter itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_IDLE: if (cnt_d != '0) state_d = CH_RUN;
      CH_RUN:  if (cnt_d == '0) state_d = CH_IDLE;
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= CH_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign pdl = (state_q == CH_RUN);

endmodule

// File: rtl/paddle_timer.sv
// ---------------------------------------------------------------------------
// paddle_timer
// Game-port paddle timer. A strobe marks a reload as pending; the next CPU
// tick loads all four paddle channels, which then count down one step per
// tick. The paddle outputs, the pushbuttons and the cassette input are
// packed onto GAMEPORT.
//   CLK_14M     in   master clock, the only clock
//   reset       in   synchronous active-high reset
//   CLK_2M      in   CPU-phase clock level, used only to derive ticks
//   pdl_strobe  in   one-cycle pulse on a $C07x access
//   pdl_an      in   four signed 8-bit positions, PDL0 in [31:24]
//   buttons     in   PB3..PB1, active high
//   TAPE_IN     in   cassette input
//   GAMEPORT    out  {pdl3, pdl2, pdl1, pdl0, pb3, pb2, pb1, TAPE_IN}
//   busy        out  high while any paddle output is high
// ---------------------------------------------------------------------------
module paddle_timer
  import paddle_timer_pkg::*;
(
  input  logic        CLK_14M,
  input  logic        reset,
  input  logic        CLK_2M,
  input  logic        pdl_strobe,
  input  logic [31:0] pdl_an,
  input  logic [2:0]  buttons,
  input  logic        TAPE_IN,
  output logic [7:0]  GAMEPORT,
  output logic        busy
);

  logic       clk_2m_prev_q;
  logic       clk_2m_prev_d;
  logic       pending_q;
  logic       pending_d;
  logic       tick;
  logic       load;
  logic [3:0] pdl;

  // CLK_2M is treated as data: a rising level seen against last cycle's
  // sample produces a one-cycle tick. A strobe arriving on a tick cycle is
  // serviced immediately rather than waiting a full CPU cycle, and the
  // pending flag is cleared by every tick whether or not it was set.
  always_comb begin
    clk_2m_prev_d = CLK_2M;
    tick          = CLK_2M & ~clk_2m_prev_q;
    load          = tick & (pending_q | pdl_strobe);
    pending_d     = tick ? 1'b0 : (pending_q | pdl_strobe);
  end

  // Reset takes priority over a same-cycle strobe, so that strobe is lost.
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      clk_2m_prev_q <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      clk_2m_prev_q <= clk_2m_prev_d;
      pending_q     <= pending_d;
    end
  end

  // Channel n takes its position from byte (3-n) of pdl_an, so PDL0 sits in
  // the most significant byte.
  for (genvar i = 0; i < 4; i++) begin : g_chan
    paddle_channel u_chan (
      .clk   (CLK_14M),
      .reset (reset),
      .tick  (tick),
      .load  (load),
      .pos   (pdl_an[31-8*i -: 8]),
      .pdl   (pdl[i])
    );
  end

  // Buttons and tape input bypass all registers.
  assign GAMEPORT = {pdl, buttons, TAPE_IN};
  assign busy     = |pdl;

endmodule
